// File: rtl/pc_fetch_gen.sv
// ---------------------------------------------------------------------------
// pc_fetch_gen
//
// Program-counter generator for the instruction-fetch stage. Produces the word
// address of the current fetch (pc_if), tracks the address of the instruction
// entering decode (pc_id), and applies control-flow redirects with a fixed
// priority. Redirects that arrive while the pipeline is stalled are captured
// in a pending register and applied on the first cycle the pipe advances.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   pc_start     : one-cycle start pulse, loads start_adr and begins fetching
//   start_adr    : start word address [31:2]
//   stall        : global pipeline stall
//   ic_stall     : instruction-cache miss stall
//   rst_pipe     : pipeline flush, returns the generator to IDLE
//   jmp_ex       : taken branch/jump resolved in EX, target jmp_adr_ex
//   trap_req     : exception/interrupt entry, target trap_vec
//   mret_req     : trap return, target mepc
//   pc_if        : current fetch word address
//   if_valid     : pc_if is a live fetch
//   pc_id        : address of the instruction entering ID
//   flush_if     : one-cycle kill of the instruction in IF/ID after a redirect
//   redir_pend   : a redirect has been captured but not yet applied
// ---------------------------------------------------------------------------
module pc_fetch_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_start,
    input  logic [29:0] start_adr,
    input  logic        stall,
    input  logic        ic_stall,
    input  logic        rst_pipe,
    input  logic        jmp_ex,
    input  logic [29:0] jmp_adr_ex,
    input  logic        trap_req,
    input  logic [29:0] trap_vec,
    input  logic        mret_req,
    input  logic [29:0] mepc,
    output logic [29:0] pc_if,
    output logic        if_valid,
    output logic [29:0] pc_id,
    output logic        flush_if,
    output logic        redir_pend
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state;
    logic        adv;
    logic [1:0]  new_prio;
    logic [29:0] new_adr;
    logic [1:0]  pend_prio;
    logic [29:0] pend_adr;

    assign adv = ~stall & ~ic_stall;

    // Select the highest-priority fresh redirect among the ordinary sources.
    // Encoded priority: trap=3, mret=2, jump=1, none=0. pc_start and rst_pipe
    // are handled separately because they override everything else.
    always_comb begin
        new_prio = 2'd0;
        new_adr  = '0;
        if (trap_req) begin
            new_prio = 2'd3;
            new_adr  = trap_vec;
        end else if (mret_req) begin
            new_prio = 2'd2;
            new_adr  = mepc;
        end else if (jmp_ex) begin
            new_prio = 2'd1;
            new_adr  = jmp_adr_ex;
        end
    end

    // Fetch state machine with registered outputs. pc_start acts regardless
    // of stall; rst_pipe parks the generator but keeps pc_if so the last
    // fetch address stays observable. flush_if defaults low every cycle so a
    // redirect can only produce a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc_if      <= '0;
            pc_id      <= '0;
            if_valid   <= 1'b0;
            flush_if   <= 1'b0;
            redir_pend <= 1'b0;
            pend_prio  <= 2'd0;
            pend_adr   <= '0;
        end else begin
            flush_if <= 1'b0;

            if (adv && state != IDLE)
                pc_id <= pc_if;

            if (pc_start) begin
                pc_if      <= start_adr;
                state      <= RUN;
                if_valid   <= 1'b1;
                redir_pend <= 1'b0;
                pend_prio  <= 2'd0;
            end else if (rst_pipe) begin
                state      <= IDLE;
                if_valid   <= 1'b0;
                redir_pend <= 1'b0;
                pend_prio  <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if_valid <= 1'b0;
                    end
                    RUN: begin
                        if (adv) begin
                            if (new_prio != 2'd0) begin
                                pc_if    <= new_adr;
                                flush_if <= 1'b1;
                            end else begin
                                pc_if <= pc_if + 30'd1;
                            end
                        end else if (new_prio != 2'd0) begin
                            pend_adr   <= new_adr;
                            pend_prio  <= new_prio;
                            redir_pend <= 1'b1;
                            state      <= REDIR;
                        end
                    end
                    REDIR: begin
                        if (adv) begin
                            // A fresh redirect only wins if strictly more
                            // important than the captured one.
                            pc_if      <= (new_prio > pend_prio) ? new_adr : pend_adr;
                            flush_if   <= 1'b1;
                            redir_pend <= 1'b0;
                            pend_prio  <= 2'd0;
                            state      <= RUN;
                        end else if (new_prio != 2'd0 && new_prio >= pend_prio) begin
                            pend_adr  <= new_adr;
                            pend_prio <= new_prio;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        if_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_gen
//
// Directed bench for pc_fetch_gen. Each step drives inputs just after a
// rising edge, pushes the expected outputs for the following edge onto a
// scoreboard queue, then pops and compares once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst;
    logic        pc_start;
    logic [29:0] start_adr;
    logic        stall;
    logic        ic_stall;
    logic        rst_pipe;
    logic        jmp_ex;
    logic [29:0] jmp_adr_ex;
    logic        trap_req;
    logic [29:0] trap_vec;
    logic        mret_req;
    logic [29:0] mepc;
    logic [29:0] pc_if;
    logic        if_valid;
    logic [29:0] pc_id;
    logic        flush_if;
    logic        redir_pend;

    typedef struct packed {
        logic [29:0] pc_if;
        logic [29:0] pc_id;
        logic        chk_id;
        logic        if_valid;
        logic        flush_if;
        logic        redir_pend;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    checks = 0;
    int    errors = 0;

    pc_fetch_gen dut (
        .clk        (clk),
        .rst        (rst),
        .pc_start   (pc_start),
        .start_adr  (start_adr),
        .stall      (stall),
        .ic_stall   (ic_stall),
        .rst_pipe   (rst_pipe),
        .jmp_ex     (jmp_ex),
        .jmp_adr_ex (jmp_adr_ex),
        .trap_req   (trap_req),
        .trap_vec   (trap_vec),
        .mret_req   (mret_req),
        .mepc       (mepc),
        .pc_if      (pc_if),
        .if_valid   (if_valid),
        .pc_id      (pc_id),
        .flush_if   (flush_if),
        .redir_pend (redir_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ps, input logic [29:0] sa,
                                 input logic st, input logic ics, input logic rp,
                                 input logic j, input logic [29:0] ja,
                                 input logic t, input logic [29:0] tv,
                                 input logic m, input logic [29:0] me);
        pc_start   = ps;
        start_adr  = sa;
        stall      = st;
        ic_stall   = ics;
        rst_pipe   = rp;
        jmp_ex     = j;
        jmp_adr_ex = ja;
        trap_req   = t;
        trap_vec   = tv;
        mret_req   = m;
        mepc       = me;
    endtask

    task automatic expectOut(input string tag, input logic [29:0] p,
                             input logic v, input logic f, input logic r,
                             input logic chk, input logic [29:0] id);
        exp_t e;
        e.pc_if      = p;
        e.pc_id      = id;
        e.chk_id     = chk;
        e.if_valid   = v;
        e.flush_if   = f;
        e.redir_pend = r;
        expq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = expq.pop_front();
        t = tagq.pop_front();
        checks++;
        assert (pc_if === e.pc_if) else begin
            errors++;
            $error("FAIL %s pc_if: observed %h expected %h", t, pc_if, e.pc_if);
        end
        checks++;
        assert (if_valid === e.if_valid) else begin
            errors++;
            $error("FAIL %s if_valid: observed %b expected %b", t, if_valid, e.if_valid);
        end
        checks++;
        assert (flush_if === e.flush_if) else begin
            errors++;
            $error("FAIL %s flush_if: observed %b expected %b", t, flush_if, e.flush_if);
        end
        checks++;
        assert (redir_pend === e.redir_pend) else begin
            errors++;
            $error("FAIL %s redir_pend: observed %b expected %b", t, redir_pend, e.redir_pend);
        end
        if (e.chk_id) begin
            checks++;
            assert (pc_id === e.pc_id) else begin
                errors++;
                $error("FAIL %s pc_id: observed %h expected %h", t, pc_id, e.pc_id);
            end
        end
    endtask

    task automatic tickAndCheck();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        expectOut("reset", 30'h0, 0, 0, 0, 1, 30'h0);
        checkOutput();
        rst = 1'b0;

        // Leaving reset must not start fetching on its own
        expectOut("idle_hold0", 30'h0, 0, 0, 0, 1, 30'h0);
        tickAndCheck();
        expectOut("idle_hold1", 30'h0, 0, 0, 0, 1, 30'h0);
        tickAndCheck();

        // Start at 0x100 and run sequentially
        applyStimulus(1, 30'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("start", 30'h100, 1, 0, 0, 1, 30'h0);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("seq1", 30'h101, 1, 0, 0, 1, 30'h100);
        tickAndCheck();
        expectOut("seq2", 30'h102, 1, 0, 0, 1, 30'h101);
        tickAndCheck();
        expectOut("seq3", 30'h103, 1, 0, 0, 1, 30'h102);
        tickAndCheck();

        // Jump from 0x200 to 0x40 with the pipe advancing
        applyStimulus(1, 30'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("restart200", 30'h200, 1, 0, 0, 1, 30'h103);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 1, 30'h40, 0, 0, 0, 0);
        expectOut("jmp_apply", 30'h40, 1, 1, 0, 1, 30'h200);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("jmp_after", 30'h41, 1, 0, 0, 1, 30'h40);
        tickAndCheck();

        // Jump during stall, then a higher-priority trap overrides it
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("stall_hold", 30'h41, 1, 0, 0, 1, 30'h40);
        tickAndCheck();
        applyStimulus(0, 0, 1, 0, 0, 1, 30'h80, 0, 0, 0, 0);
        expectOut("stall_jmp", 30'h41, 1, 0, 1, 1, 30'h40);
        tickAndCheck();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 30'h10, 0, 0);
        expectOut("stall_trap", 30'h41, 1, 0, 1, 1, 30'h40);
        tickAndCheck();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("stall_wait", 30'h41, 1, 0, 1, 1, 30'h40);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("release_trap", 30'h10, 1, 1, 0, 1, 30'h41);
        tickAndCheck();
        expectOut("flush_once", 30'h11, 1, 0, 0, 1, 30'h10);
        tickAndCheck();

        // Lower-priority mret must be dropped while a trap is pending
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 30'h20, 0, 0);
        expectOut("icstall_trap", 30'h11, 1, 0, 1, 1, 30'h10);
        tickAndCheck();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 30'h30);
        expectOut("mret_dropped", 30'h11, 1, 0, 1, 1, 30'h10);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("release_trap2", 30'h20, 1, 1, 0, 1, 30'h11);
        tickAndCheck();
        expectOut("after_trap2", 30'h21, 1, 0, 0, 1, 30'h20);
        tickAndCheck();

        // 30-bit wrap
        applyStimulus(1, 30'h3FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("start_max", 30'h3FFFFFFF, 1, 0, 0, 0, 30'h0);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("wrap", 30'h0, 1, 0, 0, 1, 30'h3FFFFFFF);
        tickAndCheck();

        // pc_start beats a simultaneous jump under stall
        applyStimulus(1, 30'h55, 1, 0, 0, 1, 30'h66, 0, 0, 0, 0);
        expectOut("start_vs_jmp", 30'h55, 1, 0, 0, 0, 30'h0);
        tickAndCheck();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("start_hold", 30'h55, 1, 0, 0, 0, 30'h0);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("start_no_jmp", 30'h56, 1, 0, 0, 1, 30'h55);
        tickAndCheck();

        // rst_pipe while a redirect is pending, then a clean restart
        applyStimulus(0, 0, 1, 0, 0, 1, 30'h77, 0, 0, 0, 0);
        expectOut("redir_enter", 30'h56, 1, 0, 1, 1, 30'h55);
        tickAndCheck();
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        expectOut("rst_pipe", 30'h56, 0, 0, 0, 1, 30'h55);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("idle_after_flush", 30'h56, 0, 0, 0, 1, 30'h55);
        tickAndCheck();
        applyStimulus(1, 30'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("restart300", 30'h300, 1, 0, 0, 1, 30'h55);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("seq301", 30'h301, 1, 0, 0, 1, 30'h300);
        tickAndCheck();

        // Asynchronous reset with a pending redirect discards it
        applyStimulus(0, 0, 1, 0, 0, 1, 30'h90, 0, 0, 0, 0);
        expectOut("pend_90", 30'h301, 1, 0, 1, 1, 30'h300);
        tickAndCheck();
        rst = 1'b1;
        #1;
        expectOut("async_rst", 30'h0, 0, 0, 0, 1, 30'h0);
        checkOutput();
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("rst_idle", 30'h0, 0, 0, 0, 1, 30'h0);
        tickAndCheck();
        applyStimulus(1, 30'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("post_rst_start", 30'h10, 1, 0, 0, 1, 30'h0);
        tickAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectOut("post_rst_seq", 30'h11, 1, 0, 0, 1, 30'h10);
        tickAndCheck();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
